ni_flit_buf: RTL and testbench



---
 rtl/ni_flit_buf.sv | 115 +++++++++++
 tb/tb_ni_flit_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_buf.sv
// rtl/ni_flit_buf.sv - credit-based flit buffer between the spike-output stage and the router local port
// RAM of 2^B-1 entries plus one output register; occupancy covers both.
module ni_flit_buf #(
    parameter int B   = 4,
    parameter int FW  = 59,
    parameter int FTW = 3,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flit_in_wr,
    input  logic [FW-1:0] i_flit_in,
    output logic          o_credit_out,
    output logic          o_flit_out_valid,
    output logic [FW-1:0] o_flit_out,
    input  logic          i_flit_out_ready,
    output logic          o_ni_overflow,
    output logic [CW-1:0] o_ni_flit_cnt
);

    localparam int            RAM_D    = (1 << B) - 1;
    localparam logic [B:0]    OCC_FULL = {1'b1, {B{1'b0}}};
    localparam logic [B:0]    OCC_ONE  = {{B{1'b0}}, 1'b1};
    localparam logic [B-1:0]  PTR_LAST = {{(B-1){1'b1}}, 1'b0};
    localparam logic [B-1:0]  PTR_ONE  = {{(B-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [FW-1:0] r_ram [RAM_D];
    logic [B-1:0]  r_wr_ptr;
    logic [B-1:0]  r_rd_ptr;
    logic [B:0]    r_occ;
    logic          r_pop;
    logic          r_valid;
    logic [FW-1:0] r_flit;
    logic          r_ovf;
    logic [CW-1:0] r_cnt;

    logic          w_pop;
    logic          w_wr_acc;
    logic          w_ram_empty;
    logic          w_out_free;
    logic          w_load;
    logic          w_bypass;
    logic          w_ram_wr;
    logic [B-1:0]  w_wr_ptr_nxt;
    logic [B-1:0]  w_rd_ptr_nxt;
    logic [FTW-1:0] w_unused_type;

    // The type field rides along untouched; it is never decoded here.
    assign w_unused_type = i_flit_in[FW-1:FW-FTW];

    assign w_pop       = r_valid & i_flit_out_ready;
    assign w_wr_acc    = i_flit_in_wr & ((r_occ != OCC_FULL) | w_pop);
    assign w_ram_empty = (r_occ == {{B{1'b0}}, r_valid});
    assign w_out_free  = ~r_valid | w_pop;
    assign w_load      = w_out_free & ~w_ram_empty;
    assign w_bypass    = w_out_free & w_ram_empty & w_wr_acc;
    assign w_ram_wr    = w_wr_acc & ~w_bypass;

    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;

    // RAM is not reset; full RAM with a refill reads the old word before the write lands.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[r_wr_ptr] <= i_flit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_pop    <= 1'b0;
            r_valid  <= 1'b0;
            r_flit   <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_pop <= w_pop;
            if (w_ram_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_load) begin
                r_flit   <= r_ram[r_rd_ptr];
                r_valid  <= 1'b1;
                r_rd_ptr <= w_rd_ptr_nxt;
            end else if (w_bypass) begin
                r_flit  <= i_flit_in;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
            if (i_flit_in_wr && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_credit_out     = r_pop;
    assign o_flit_out_valid = r_valid;
    assign o_flit_out       = r_flit;
    assign o_ni_overflow    = r_ovf;
    assign o_ni_flit_cnt    = r_cnt;

endmodule

// File: tb/tb_ni_flit_buf.sv
// tb/tb_ni_flit_buf.sv - directed vector table plus corner-case sequences for ni_flit_buf
module tb_ni_flit_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_wr;
    logic [58:0] i_din;
    logic        o_credit;
    logic        o_valid;
    logic [58:0] o_flit;
    logic        i_rdy;
    logic        o_ovf;
    logic [15:0] o_cnt;

    int total = 0;
    int bad   = 0;
    logic [58:0] exp_q[$];

    always #5 clk = ~clk;

    ni_flit_buf #(.B(4), .FW(59), .FTW(3), .CW(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_flit_in_wr     (i_wr),
        .i_flit_in        (i_din),
        .o_credit_out     (o_credit),
        .o_flit_out_valid (o_valid),
        .o_flit_out       (o_flit),
        .i_flit_out_ready (i_rdy),
        .o_ni_overflow    (o_ovf),
        .o_ni_flit_cnt    (o_cnt)
    );

    typedef struct {
        logic        wr;
        logic [58:0] din;
        logic        rdy;
        logic        ev;
        logic [58:0] eflit;
        logic        ecred;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic wr, input logic [58:0] d, input logic rdy);
        i_wr  = wr;
        i_din = d;
        i_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_wr  = 1'b0;
        i_din = '0;
        i_rdy = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    function automatic logic [58:0] mk(input int i);
        logic [2:0] t;
        case (i % 5)
            0:       t = 3'b000;
            1:       t = 3'b001;
            2:       t = 3'b010;
            3:       t = 3'b110;
            default: t = 3'b111;
        endcase
        return {t, 24'hA5A5A5, 32'(i)};
    endfunction

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            step(1'b1, mk(base + i), 1'b0);
            exp_q.push_back(mk(base + i));
        end
        i_wr = 1'b0;
    endtask

    task automatic drain_expect(input int n, input string tag);
        int got;
        int budget;
        logic [58:0] e;
        got    = 0;
        budget = 4 * n + 10;
        i_wr   = 1'b0;
        i_rdy  = 1'b1;
        while (budget > 0 && (o_valid || exp_q.size() > 0)) begin
            if (o_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                chk({tag, "_order"}, 64'(o_flit), 64'(e));
                got++;
            end
            step(1'b0, '0, 1'b1);
            budget--;
        end
        i_rdy = 1'b0;
        chk({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        int credits;
        int sent;
        int rcv;
        int cyc;
        logic        r_w;
        logic        r_r;
        logic [63:0] rnd;
        logic [58:0] e;

        vecs[0]  = '{1'b1, 59'h1,                  1'b0, 1'b1, 59'h1,                  1'b0, 16'd0};
        vecs[1]  = '{1'b0, 59'h0,                  1'b1, 1'b0, 59'h0,                  1'b1, 16'd1};
        vecs[2]  = '{1'b1, 59'h6_00_1122_3344_5566, 1'b1, 1'b1, 59'h6_00_1122_3344_5566, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 59'h7_00_AABB_CCDD_EEFF, 1'b1, 1'b1, 59'h7_00_AABB_CCDD_EEFF, 1'b1, 16'd2};
        vecs[4]  = '{1'b1, 59'h1_12_3456_789A_BCDE, 1'b0, 1'b1, 59'h7_00_AABB_CCDD_EEFF, 1'b0, 16'd2};
        vecs[5]  = '{1'b1, 59'h2_FF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 59'h7_00_AABB_CCDD_EEFF, 1'b0, 16'd2};
        vecs[6]  = '{1'b0, 59'h0,                  1'b1, 1'b1, 59'h1_12_3456_789A_BCDE, 1'b1, 16'd3};
        vecs[7]  = '{1'b0, 59'h0,                  1'b1, 1'b1, 59'h2_FF_FFFF_FFFF_FFFF, 1'b1, 16'd4};
        vecs[8]  = '{1'b0, 59'h0,                  1'b0, 1'b1, 59'h2_FF_FFFF_FFFF_FFFF, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 59'h0,                  1'b1, 1'b0, 59'h0,                  1'b1, 16'd5};
        vecs[10] = '{1'b0, 59'h0,                  1'b1, 1'b0, 59'h0,                  1'b0, 16'd5};

        rst_n = 1'b0;
        i_wr  = 1'b0;
        i_din = '0;
        i_rdy = 1'b0;
        do_reset();
        chk("rst_valid",  64'(o_valid),  64'd0);
        chk("rst_flit",   64'(o_flit),   64'd0);
        chk("rst_credit", 64'(o_credit), 64'd0);
        chk("rst_ovf",    64'(o_ovf),    64'd0);
        chk("rst_cnt",    64'(o_cnt),    64'd0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].din, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("vec%0d_flit", i), 64'(o_flit), 64'(vecs[i].eflit));
            chk($sformatf("vec%0d_credit", i), 64'(o_credit), 64'(vecs[i].ecred));
            chk($sformatf("vec%0d_cnt", i),    64'(o_cnt),    64'(vecs[i].ecnt));
            chk($sformatf("vec%0d_ovf", i),    64'(o_ovf),    64'd0);
        end

        // 15 writes then 15 back-to-back pops with lagging credit pulses
        do_reset();
        fill(15, 100);
        chk("b15_ovf", 64'(o_ovf), 64'd0);
        for (int i = 0; i < 15; i++) begin
            e = exp_q.pop_front();
            chk("b15_valid", 64'(o_valid), 64'd1);
            chk("b15_order", 64'(o_flit),  64'(e));
            step(1'b0, '0, 1'b1);
            chk("b15_credit", 64'(o_credit), 64'd1);
        end
        step(1'b0, '0, 1'b0);
        chk("b15_credit_end", 64'(o_credit), 64'd0);
        chk("b15_empty",      64'(o_valid),  64'd0);
        chk("b15_cnt",        64'(o_cnt),    64'd15);

        // 17th write into a full buffer is dropped
        do_reset();
        fill(16, 200);
        chk("full16_ovf", 64'(o_ovf), 64'd0);
        step(1'b1, mk(999), 1'b0);
        chk("drop_ovf",    64'(o_ovf),    64'd1);
        chk("drop_credit", 64'(o_credit), 64'd0);
        drain_expect(16, "drop");
        chk("drop_sticky", 64'(o_ovf), 64'd1);

        // full buffer with a write and pop in the same cycle
        do_reset();
        fill(16, 300);
        e = exp_q.pop_front();
        chk("fwp_head", 64'(o_flit), 64'(e));
        exp_q.push_back(mk(400));
        step(1'b1, mk(400), 1'b1);
        chk("fwp_ovf",    64'(o_ovf),    64'd0);
        chk("fwp_credit", 64'(o_credit), 64'd1);
        step(1'b1, mk(401), 1'b0);
        chk("fwp_still_full", 64'(o_ovf), 64'd1);
        drain_expect(16, "fwp");
        chk("fwp_cnt", 64'(o_cnt), 64'd17);

        // randomised ready against a credit-paced sender
        do_reset();
        credits = 15;
        sent    = 0;
        rcv     = 0;
        cyc     = 0;
        while (rcv < 1000 && cyc < 20000) begin
            r_w = (credits > 0) && (sent < 1000);
            rnd = {$urandom, $urandom};
            if (r_w) begin
                exp_q.push_back(rnd[58:0]);
                credits--;
                sent++;
            end
            r_r = 1'($urandom_range(0, 1));
            if (o_valid && r_r) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                chk("rnd_order", 64'(o_flit), 64'(e));
                rcv++;
            end
            step(r_w, rnd[58:0], r_r);
            if (o_credit) credits++;
            cyc++;
        end
        chk("rnd_rcv",     64'(rcv),     64'd1000);
        chk("rnd_ovf",     64'(o_ovf),   64'd0);
        chk("rnd_cnt",     64'(o_cnt),   64'd1000);
        chk("rnd_credits", 64'(credits), 64'd15);

        // asynchronous reset with 8 flits buffered
        do_reset();
        fill(9, 500);
        exp_q.delete();
        step(1'b0, '0, 1'b1);
        i_rdy = 1'b0;
        chk("ar_pre_credit", 64'(o_credit), 64'd1);
        chk("ar_pre_valid",  64'(o_valid),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  64'(o_valid),  64'd0);
        chk("ar_flit",   64'(o_flit),   64'd0);
        chk("ar_credit", 64'(o_credit), 64'd0);
        chk("ar_ovf",    64'(o_ovf),    64'd0);
        chk("ar_cnt",    64'(o_cnt),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("ar_idle_valid", 64'(o_valid), 64'd0);
        step(1'b1, 59'h3_00_DEAD_BEEF_0042, 1'b0);
        chk("ar_new_valid", 64'(o_valid), 64'd1);
        chk("ar_new_flit",  64'(o_flit),  64'(59'h3_00_DEAD_BEEF_0042));
        step(1'b0, '0, 1'b1);
        chk("ar_no_stale", 64'(o_valid), 64'd0);
        chk("ar_cnt_after", 64'(o_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
